bme_pp_row_gen: RTL
===================

// Module: bme_pp_row_gen
// PURPOSE
//  Parametrised, row-serial partial-product generator for the reversible-logic
//  multiplier datapath in the matrix-multiplier PE. Captures operand pair A,B,
//  then emits one WIDTH-bit partial-product row per accepted cycle, built from
//  WIDTH/2 bme_gate cells. Supports unsigned and signed (Baugh-Wooley) modes.
//  Feeds the downstream reversible adder tree through a valid/ready stream.
// PARAMETERS
//  WIDTH  8  operand width in bits; even, >= 4
//  IDXW   $clog2(WIDTH)  width of row index (derived; do not override)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can capture an operand pair this cycle
//  in_a       in   WIDTH  multiplicand A
//  in_b       in   WIDTH  multiplier B (row i selected by B[i])
//  in_signed  in   1      1 = two's-complement Baugh-Wooley mode
//  pp_valid   out  1      pp_row/pp_idx/pp_last/pp_signed valid
//  pp_ready   in   1      downstream accepts current row
//  pp_row     out  WIDTH  partial-product row i (unshifted)
//  pp_idx     out  IDXW   row index i, 0..WIDTH-1
//  pp_last    out  1      high with row WIDTH-1
//  pp_signed  out  1      captured in_signed for this operand pair
// BEHAVIOUR
//  - Clock clk; reset rst synchronous, active-high.
//  - Reset: state IDLE; pp_valid=0, pp_row=0, pp_idx=0, pp_last=0, pp_signed=0;
//    in_ready=1 in the first cycle after reset deasserts. Reset wins over all.
//  - Cell k (0..WIDTH/2-1) of row i: a=B[i], b=A[2k], c=0, d=A[2k+1];
//    pp_row[2k]=x, pp_row[2k+1]=y. w and z outputs are garbage, left unused.
//  - Signed mode inversion mask, XORed after cells: row i<WIDTH-1 inverts bit
//    WIDTH-1 only; row WIDTH-1 inverts bits 0..WIDTH-2, bit WIDTH-1 untouched.
//    Unsigned mode: no inversion. Adder tree adds BW constants (not this block).
//  - Handshake: transfer when valid&&ready on each side. pp_row/pp_idx/pp_last/
//    pp_signed held stable while pp_valid=1 && pp_ready=0. pp_valid never drops
//    without a transfer (except rst).
//  - FSM IDLE: in_ready=1, pp_valid=0. On in_valid: capture A,B,signed; idx=0;
//    -> GEN; row 0 presented with pp_valid=1 next cycle (latency 1).
//  - FSM GEN: pp_valid=1. On pp_ready & !pp_last: idx+1, next row next cycle.
//    On pp_ready & pp_last: if in_valid, capture new pair and present its row 0
//    next cycle (stay GEN, no bubble); else -> IDLE, pp_valid=0 next cycle.
//  - in_ready = IDLE | (GEN & pp_last & pp_ready). in_valid ignored otherwise;
//    in_a/in_b changes in GEN do not affect the rows being emitted.
//  - Throughput: WIDTH cycles per operand pair with pp_ready held high.
//  - idx never wraps beyond WIDTH-1; pp_last = (idx==WIDTH-1).
// TESTING (WIDTH=4)
//  - Reset: assert rst 2 cycles mid-GEN -> next cycle pp_valid=0, pp_idx=0,
//    in_ready=1; no further rows from aborted pair.
//  - Unsigned A=4'b1011, B=4'b0101, pp_ready=1 -> rows 1011,0000,1011,0000 on
//    idx 0..3 in 4 consecutive cycles, pp_last only on idx 3, then pp_valid=0.
//  - Signed A=4'b1011(-5), B=4'b0110(6) -> rows 1000,0011,0011,0111; pp_signed=1.
//  - Backpressure: pp_ready=0 for 3 cycles on idx 2 -> pp_row/pp_idx stable,
//    resumes with idx 3 after pp_ready=1; no row lost or duplicated.
//  - Back-to-back: in_valid held with second pair A=4'b1111,B=4'b0011 ->
//    in_ready=1 only in idx-3 cycle; second pair row 0 (1111) follows with no gap.
//  - in_valid pulsed during GEN idx 1 -> ignored (in_ready=0), rows unchanged.

Source files
------------

// File: rtl/bme_pp_row_gen_if.sv
// Operand-pair input stream and partial-product row output stream of bme_pp_row_gen.
interface bme_pp_row_gen_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned IDXW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_signed;
   logic             pp_valid;
   logic             pp_ready;
   logic [WIDTH-1:0] pp_row;
   logic [IDXW-1:0]  pp_idx;
   logic             pp_last;
   logic             pp_signed;

   // Upstream/downstream environment side.
   modport master (
      output in_valid, in_a, in_b, in_signed, pp_ready,
      input  in_ready, pp_valid, pp_row, pp_idx, pp_last, pp_signed
   );

   // Row generator side.
   modport slave (
      input  in_valid, in_a, in_b, in_signed, pp_ready,
      output in_ready, pp_valid, pp_row, pp_idx, pp_last, pp_signed
   );
endinterface

// File: rtl/bme_pp_row_gen.sv
// Row-serial partial-product generator built from BME gate cells, with optional
// Baugh-Wooley inversion mask; emits one row per accepted cycle on a valid/ready stream.
module bme_pp_row_gen #(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   bme_pp_row_gen_if.slave  bus
);
   localparam int unsigned IDXW  = $clog2(WIDTH);
   localparam int unsigned CELLS = WIDTH / 2;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_GEN  = 1'b1;

   logic             state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;
   logic [IDXW-1:0]  idx_q;

   logic             last;
   logic             row_done;
   logic             ready;
   logic             capture;
   logic             sel;
   logic [WIDTH-1:0] cell_row;
   logic [WIDTH-1:0] mask;

   assign last     = (idx_q == LAST_IDX);
   assign row_done = (state_q == ST_GEN) && bus.pp_ready;
   assign ready    = (state_q == ST_IDLE) || (row_done && last);
   assign capture  = bus.in_valid && ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         idx_q   <= '0;
      end else if (capture) begin
         state_q <= ST_GEN;
         a_q     <= bus.in_a;
         b_q     <= bus.in_b;
         sgn_q   <= bus.in_signed;
         idx_q   <= '0;
      end else if (row_done) begin
         if (last) begin
            // Return idx to 0 so pp_last stays low while idle.
            state_q <= ST_IDLE;
            idx_q   <= '0;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign sel = b_q[idx_q];

   // BME cell k: a=B[i], b=A[2k], c=0, d=A[2k+1]; x=ab^c, y=ad^c. Garbage outputs unused.
   for (genvar k = 0; k < CELLS; k++) begin : g_cell
      logic cell_a, cell_b, cell_c, cell_d;
      assign cell_a            = sel;
      assign cell_b            = a_q[2*k];
      assign cell_c            = 1'b0;
      assign cell_d            = a_q[2*k+1];
      assign cell_row[2*k]     = (cell_a & cell_b) ^ cell_c;
      assign cell_row[2*k+1]   = (cell_a & cell_d) ^ cell_c;
   end

   always_comb begin
      mask = '0;
      if (sgn_q) begin
         if (last) begin
            mask = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            mask = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.pp_valid  = (state_q == ST_GEN);
   assign bus.pp_row    = cell_row ^ mask;
   assign bus.pp_idx    = idx_q;
   assign bus.pp_last   = last;
   assign bus.pp_signed = sgn_q;
endmodule
